player_damage_tracker: RTL and testbench

//  N-player damage/stock/hitstun tracker for the match core. Consumes per-player hit events from
//  the collision system and keeps damage %, stocks, hitstun and post-respawn invulnerability.

---
 rtl/player_damage_tracker.sv | 194 +++++++++++++++++++
 tb/tb_player_damage_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_damage_tracker.sv
// Per-player damage / stock / hitstun / invulnerability tracker for the match core.
// Each player runs an independent four-state FSM; match end is detected from the
// next-state of all players, and once the match is over every player is frozen.
module player_damage_tracker #(
  parameter int NUM_PLAYERS   = 2,
  parameter int DMG_W         = 10,
  parameter int MAX_DAMAGE    = 999,
  parameter int KO_THRESHOLD  = 100,
  parameter int START_STOCKS  = 3,
  parameter int STOCK_W       = 2,
  parameter int BASE_STUN     = 20,
  parameter int STUN_SHIFT    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  frame_tick,
  input  logic [NUM_PLAYERS-1:0]                hit_valid,
  input  logic [6*NUM_PLAYERS-1:0]              hit_damage,
  output logic [NUM_PLAYERS-1:0]                hit_stun_active,
  output logic [NUM_PLAYERS-1:0]                invuln_active,
  output logic [DMG_W*NUM_PLAYERS-1:0]          damage,
  output logic [STOCK_W*NUM_PLAYERS-1:0]        stocks,
  output logic [NUM_PLAYERS-1:0]                respawn_pulse,
  output logic [NUM_PLAYERS-1:0]                eliminated,
  output logic                                  game_over,
  output logic [$clog2(NUM_PLAYERS+1)-1:0]      winner
);

  localparam int WIN_W = $clog2(NUM_PLAYERS+1);
  localparam int ALIVE_W = $clog2(NUM_PLAYERS+1) + 1;

  // Constants pre-sized so every comparison happens at the widened damage width.
  localparam logic [DMG_W:0]   MAX_DMG_X   = (DMG_W+1)'(MAX_DAMAGE);
  localparam logic [DMG_W:0]   KO_X        = (DMG_W+1)'(KO_THRESHOLD);
  localparam logic [STOCK_W-1:0] START_STK = STOCK_W'(START_STOCKS);
  localparam logic [7:0]       INV_LOAD    = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_STUNNED,
    ST_INVULN,
    ST_ELIM
  } state_t;

  state_t               state_q [NUM_PLAYERS];
  state_t               state_d [NUM_PLAYERS];
  logic [DMG_W-1:0]     dmg_q   [NUM_PLAYERS];
  logic [DMG_W-1:0]     dmg_d   [NUM_PLAYERS];
  logic [STOCK_W-1:0]   stock_q [NUM_PLAYERS];
  logic [STOCK_W-1:0]   stock_d [NUM_PLAYERS];
  logic [7:0]           stun_q  [NUM_PLAYERS];
  logic [7:0]           stun_d  [NUM_PLAYERS];
  logic [7:0]           inv_q   [NUM_PLAYERS];
  logic [7:0]           inv_d   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] pulse_q;
  logic [NUM_PLAYERS-1:0] pulse_d;
  logic                 go_q;
  logic                 go_d;
  logic [WIN_W-1:0]     win_q;
  logic [WIN_W-1:0]     win_d;

  logic                 accept;
  logic [DMG_W:0]       dmg_sum;
  logic [DMG_W-1:0]     new_dmg;
  logic [31:0]          stun_full;
  logic [ALIVE_W-1:0]   alive;
  logic [WIN_W-1:0]     survivor;

  // Next-state for every player, then match-end detection on those next states.
  always_comb begin
    accept    = 1'b0;
    dmg_sum   = '0;
    new_dmg   = '0;
    stun_full = '0;
    alive     = '0;
    survivor  = '0;
    pulse_d   = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      state_d[p] = state_q[p];
      dmg_d[p]   = dmg_q[p];
      stock_d[p] = stock_q[p];
      stun_d[p]  = stun_q[p];
      inv_d[p]   = inv_q[p];

      accept    = hit_valid[p] && (state_q[p] == ST_ACTIVE || state_q[p] == ST_STUNNED);
      dmg_sum   = {1'b0, dmg_q[p]} + {{(DMG_W-5){1'b0}}, hit_damage[6*p +: 6]};
      new_dmg   = (dmg_sum > MAX_DMG_X) ? MAX_DMG_X[DMG_W-1:0] : dmg_sum[DMG_W-1:0];
      stun_full = 32'(BASE_STUN) + 32'(new_dmg >> STUN_SHIFT);

      if (!go_q) begin
        if (accept) begin
          if (KO_THRESHOLD != 0 && {1'b0, new_dmg} >= KO_X) begin
            dmg_d[p]  = '0;
            stun_d[p] = '0;
            if (stock_q[p] > STOCK_W'(1)) begin
              stock_d[p] = stock_q[p] - STOCK_W'(1);
              inv_d[p]   = INV_LOAD;
              state_d[p] = (INVULN_FRAMES == 0) ? ST_ACTIVE : ST_INVULN;
              pulse_d[p] = 1'b1;
            end else begin
              stock_d[p] = '0;
              inv_d[p]   = '0;
              state_d[p] = ST_ELIM;
            end
          end else begin
            dmg_d[p]   = new_dmg;
            stun_d[p]  = (stun_full > 32'd255) ? 8'hFF : stun_full[7:0];
            state_d[p] = ST_STUNNED;
          end
        end else if (frame_tick) begin
          case (state_q[p])
            ST_STUNNED: begin
              if (stun_q[p] <= 8'd1) begin
                stun_d[p]  = '0;
                state_d[p] = ST_ACTIVE;
              end else begin
                stun_d[p]  = stun_q[p] - 8'd1;
              end
            end
            ST_INVULN: begin
              if (inv_q[p] <= 8'd1) begin
                inv_d[p]   = '0;
                state_d[p] = ST_ACTIVE;
              end else begin
                inv_d[p]   = inv_q[p] - 8'd1;
              end
            end
            default: ;
          endcase
        end
      end

      if (state_d[p] != ST_ELIM) begin
        alive    = alive + ALIVE_W'(1);
        survivor = WIN_W'(p);
      end
    end

    go_d  = go_q;
    win_d = win_q;
    if (!go_q && KO_THRESHOLD != 0 && alive <= ALIVE_W'(1)) begin
      go_d  = 1'b1;
      win_d = (alive == '0) ? WIN_W'(NUM_PLAYERS) : survivor;
    end
  end

  // State and counter registers; synchronous reset drops any pending pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        state_q[p] <= ST_ACTIVE;
        dmg_q[p]   <= '0;
        stock_q[p] <= START_STK;
        stun_q[p]  <= '0;
        inv_q[p]   <= '0;
      end
      pulse_q <= '0;
      go_q    <= 1'b0;
      win_q   <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        state_q[p] <= state_d[p];
        dmg_q[p]   <= dmg_d[p];
        stock_q[p] <= stock_d[p];
        stun_q[p]  <= stun_d[p];
        inv_q[p]   <= inv_d[p];
      end
      pulse_q <= pulse_d;
      go_q    <= go_d;
      win_q   <= win_d;
    end
  end

  // Pack the per-player registers onto the flat output buses.
  always_comb begin
    hit_stun_active = '0;
    invuln_active   = '0;
    eliminated      = '0;
    damage          = '0;
    stocks          = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      hit_stun_active[p]            = (state_q[p] == ST_STUNNED);
      invuln_active[p]              = (state_q[p] == ST_INVULN);
      eliminated[p]                 = (state_q[p] == ST_ELIM);
      damage[DMG_W*p +: DMG_W]      = dmg_q[p];
      stocks[STOCK_W*p +: STOCK_W]  = stock_q[p];
    end
    respawn_pulse = pulse_q;
    game_over     = go_q;
    winner        = win_q;
  end

endmodule

// File: tb/tb_player_damage_tracker.sv
// Directed bench: one tracker with default parameters plus one with KO disabled.
module tb_player_damage_tracker;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic [1:0]  hit_valid;
  logic [11:0] hit_damage;
  logic [1:0]  hit_stun_active;
  logic [1:0]  invuln_active;
  logic [19:0] damage;
  logic [3:0]  stocks;
  logic [1:0]  respawn_pulse;
  logic [1:0]  eliminated;
  logic        game_over;
  logic [1:0]  winner;

  logic [1:0]  hit_valid_b;
  logic [11:0] hit_damage_b;
  logic [1:0]  hit_stun_active_b;
  logic [1:0]  invuln_active_b;
  logic [19:0] damage_b;
  logic [3:0]  stocks_b;
  logic [1:0]  respawn_pulse_b;
  logic [1:0]  eliminated_b;
  logic        game_over_b;
  logic [1:0]  winner_b;

  int assertCount = 0;
  int failCount   = 0;

  player_damage_tracker dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .hit_valid(hit_valid), .hit_damage(hit_damage),
    .hit_stun_active(hit_stun_active), .invuln_active(invuln_active),
    .damage(damage), .stocks(stocks), .respawn_pulse(respawn_pulse),
    .eliminated(eliminated), .game_over(game_over), .winner(winner)
  );

  player_damage_tracker #(.KO_THRESHOLD(0)) dut_noko (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .hit_valid(hit_valid_b), .hit_damage(hit_damage_b),
    .hit_stun_active(hit_stun_active_b), .invuln_active(invuln_active_b),
    .damage(damage_b), .stocks(stocks_b), .respawn_pulse(respawn_pulse_b),
    .eliminated(eliminated_b), .game_over(game_over_b), .winner(winner_b)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; outputs are sampled 1 ns after the edge, inputs then cleared.
  task automatic applyStimulus(input logic [1:0] hv, input logic [5:0] d1, input logic [5:0] d0,
                               input logic hit_b, input logic tick);
    hit_valid    = hv;
    hit_damage   = {d1, d0};
    hit_valid_b  = {1'b0, hit_b};
    hit_damage_b = {6'd0, 6'd63};
    frame_tick   = tick;
    @(posedge clk);
    #1;
    hit_valid    = '0;
    hit_damage   = '0;
    hit_valid_b  = '0;
    frame_tick   = 1'b0;
  endtask

  task automatic tickFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
  endtask

  task automatic hitBoth(input logic [5:0] d1, input logic [5:0] d0);
    applyStimulus(2'b11, d1, d0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Directed scenario sequence.
  initial begin
    reset        = 1'b1;
    frame_tick   = 1'b0;
    hit_valid    = '0;
    hit_damage   = '0;
    hit_valid_b  = '0;
    hit_damage_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("rst_damage", damage, 0);
    checkOutput("rst_stocks", stocks, 4'hF);
    checkOutput("rst_flags", {hit_stun_active, invuln_active, respawn_pulse, eliminated}, 0);
    checkOutput("rst_game_over", game_over, 0);
    checkOutput("rst_winner", winner, 0);

    // Basic hit: 12 damage, stun 20 + 12>>3 = 21 frames.
    applyStimulus(2'b01, 6'd0, 6'd12, 1'b0, 1'b0);
    checkOutput("hit12_damage", damage, 12);
    checkOutput("hit12_stun", hit_stun_active, 2'b01);
    tickFrames(20);
    checkOutput("stun_after20", hit_stun_active, 2'b01);
    tickFrames(1);
    checkOutput("stun_after21", hit_stun_active, 2'b00);

    // Bring P0 to 95 then KO with 10 while holding 3 stocks.
    applyStimulus(2'b01, 6'd0, 6'd63, 1'b0, 1'b0);
    applyStimulus(2'b01, 6'd0, 6'd20, 1'b0, 1'b0);
    checkOutput("p0_at95", damage, 95);
    applyStimulus(2'b01, 6'd0, 6'd10, 1'b0, 1'b0);
    checkOutput("ko_stocks", stocks, 4'b1110);
    checkOutput("ko_damage", damage, 0);
    checkOutput("ko_pulse", respawn_pulse, 2'b01);
    checkOutput("ko_invuln", invuln_active, 2'b01);
    checkOutput("ko_stun", hit_stun_active, 2'b00);
    applyStimulus(2'b01, 6'd0, 6'd5, 1'b0, 1'b0);
    checkOutput("pulse_one_cycle", respawn_pulse, 2'b00);
    checkOutput("invuln_hit_ignored", damage, 0);
    tickFrames(59);
    checkOutput("invuln_after59", invuln_active, 2'b01);
    tickFrames(1);
    checkOutput("invuln_after60", invuln_active, 2'b00);

    // Hit together with frame_tick: 8 damage, stun 21 loaded without decrement.
    applyStimulus(2'b01, 6'd0, 6'd8, 1'b0, 1'b1);
    checkOutput("coinc_damage", damage, 8);
    tickFrames(20);
    checkOutput("coinc_after20", hit_stun_active, 2'b01);
    tickFrames(1);
    checkOutput("coinc_after21", hit_stun_active, 2'b00);

    // Reset in the middle of stun.
    applyStimulus(2'b01, 6'd0, 6'd1, 1'b0, 1'b0);
    checkOutput("pre_reset_stun", hit_stun_active, 2'b01);
    resetDut();
    checkOutput("midstun_rst_damage", damage, 0);
    checkOutput("midstun_rst_stocks", stocks, 4'hF);
    checkOutput("midstun_rst_stun", hit_stun_active, 2'b00);

    // Reset coincident with a KO hit drops the respawn pulse.
    applyStimulus(2'b01, 6'd0, 6'd63, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(2'b01, 6'd0, 6'd40, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("ko_rst_pulse", respawn_pulse, 2'b00);
    checkOutput("ko_rst_stocks", stocks, 4'hF);
    checkOutput("ko_rst_invuln", invuln_active, 2'b00);

    // Draw: both players down to 1 stock at 99, then both hit 5 in the same cycle.
    hitBoth(6'd63, 6'd63);
    hitBoth(6'd63, 6'd63);
    checkOutput("draw_ko1_stocks", stocks, 4'b1010);
    tickFrames(60);
    hitBoth(6'd63, 6'd63);
    hitBoth(6'd63, 6'd63);
    checkOutput("draw_ko2_stocks", stocks, 4'b0101);
    tickFrames(60);
    hitBoth(6'd63, 6'd63);
    hitBoth(6'd36, 6'd36);
    checkOutput("draw_at99", damage, {10'd99, 10'd99});
    checkOutput("draw_not_over", game_over, 0);
    hitBoth(6'd5, 6'd5);
    checkOutput("draw_game_over", game_over, 1);
    checkOutput("draw_winner", winner, 2);
    checkOutput("draw_elim", eliminated, 2'b11);
    checkOutput("draw_no_pulse", respawn_pulse, 2'b00);
    checkOutput("draw_stocks", stocks, 0);

    // Single elimination: P1 down to 1 stock at 95, then hit 10.
    resetDut();
    applyStimulus(2'b10, 6'd63, 6'd0, 1'b0, 1'b0);
    applyStimulus(2'b10, 6'd63, 6'd0, 1'b0, 1'b0);
    tickFrames(60);
    applyStimulus(2'b10, 6'd63, 6'd0, 1'b0, 1'b0);
    applyStimulus(2'b10, 6'd63, 6'd0, 1'b0, 1'b0);
    tickFrames(60);
    applyStimulus(2'b10, 6'd63, 6'd0, 1'b0, 1'b0);
    applyStimulus(2'b10, 6'd32, 6'd0, 1'b0, 1'b0);
    checkOutput("p1_at95", damage, {10'd95, 10'd0});
    checkOutput("p1_one_stock", stocks, 4'b0111);
    applyStimulus(2'b10, 6'd10, 6'd0, 1'b0, 1'b0);
    checkOutput("p1_elim", eliminated, 2'b10);
    checkOutput("p1_no_pulse", respawn_pulse, 2'b00);
    checkOutput("p1_game_over", game_over, 1);
    checkOutput("p1_winner", winner, 0);
    checkOutput("p1_stocks", stocks, 4'b0011);
    applyStimulus(2'b01, 6'd0, 6'd20, 1'b0, 1'b1);
    checkOutput("frozen_damage", damage, 0);
    checkOutput("frozen_stun", hit_stun_active, 2'b00);

    // KO disabled: sixteen hits of 63 saturate at 999, stun 20 + 124 = 144.
    resetDut();
    for (int i = 0; i < 15; i++) applyStimulus(2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    checkOutput("noko_945", damage_b, 945);
    applyStimulus(2'b00, 6'd0, 6'd0, 1'b1, 1'b0);
    checkOutput("noko_sat", damage_b, 999);
    checkOutput("noko_stocks", stocks_b, 4'hF);
    checkOutput("noko_game_over", game_over_b, 0);
    tickFrames(143);
    checkOutput("noko_stun143", hit_stun_active_b, 2'b01);
    tickFrames(1);
    checkOutput("noko_stun144", hit_stun_active_b, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
